// File: rtl/fpu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_sequencer_pkg
// Purpose  : Shared definitions for the binary32 multiply sequencer: FSM
//            state encodings, rounding-mode codes, binary32 constants and the
//            rounding-mode resolution helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_mul_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int          FP32_BIAS       = 127;
    localparam logic [31:0] FP32_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [30:0] FP32_MAX_FINITE = 31'h7F7F_FFFF;

    // DYN in the instruction field selects the fcsr mode.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

    // 101/110/111 are not legal after resolution.
    function automatic logic rm_is_reserved(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_round_decide.sv
`default_nettype none
// ============================================================================
// Module   : fpu_round_decide
// Purpose  : Combinational round-increment decision from the guard bits
//            {L,R,S}, the resolved rounding mode and the result sign.
// Ports    : l, r, s   in  1  LSB of kept mantissa, round bit, sticky bit
//            rm        in  3  resolved rounding mode (reserved codes -> RNE)
//            sign      in  1  result sign
//            round_up  out 1  add one ulp to the mantissa
// Revision : 1.0 - initial release
// ============================================================================
module fpu_round_decide
    import fpu_mul_sequencer_pkg::*;
(
    input  logic       l,
    input  logic       r,
    input  logic       s,
    input  logic [2:0] rm,
    input  logic       sign,
    output logic       round_up
);

    always_comb begin
        round_up = r & (l | s);
        case (rm)
            RM_RNE:  round_up = r & (l | s);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & (r | s);
            RM_RUP:  round_up = ~sign & (r | s);
            RM_RMM:  round_up = r;
            default: round_up = r & (l | s);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_sequencer
// Purpose  : Multi-cycle binary32 multiply controller. One operation in
//            flight; iterative shift-add mantissa multiply, normalize,
//            L/R/S extraction, rounding and packing of the IEEE result.
// Ports    : clk_i        in  1   clock
//            reset_i      in  1   synchronous active-low reset
//            in_valid_i   in  1   request valid
//            in_ready_o   out 1   high only in IDLE
//            a_i, b_i     in  32  binary32 operands
//            rm_i         in  3   instruction rounding mode (111 = DYN)
//            frm_i        in  3   fcsr.frm, used when rm_i is DYN
//            kill_i       in  1   squash the in-flight operation
//            out_valid_o  out 1   result valid, held until out_ready_i
//            out_ready_i  in  1   consumer accepts the result
//            result_o     out 32  packed result
//            rm_err_o     out 1   resolved rm was reserved
//            fflags_o     out 5   {NV,DZ,OF,UF,NX}, only with FPU_MUL_FLAGS_EN
// Config   : FPU_MUL_FLAGS_EN - adds fflags_o and the exception flag logic.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_sequencer
    import fpu_mul_sequencer_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  rm_i,
    input  logic [2:0]  frm_i,
    input  logic        kill_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        rm_err_o
`ifdef FPU_MUL_FLAGS_EN
    ,
    output logic [4:0]  fflags_o
`endif
);

    localparam int MUL_CYCLES = 24 / BITS_PER_CYCLE;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Operand classification (subnormals count as zero)
    // ------------------------------------------------------------------
    logic [7:0] a_exp, b_exp;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic       inf_zero, special, sign_in, accept;
    logic [2:0] rm_res;
    logic [31:0] spec_res;
    logic signed [9:0] exp_sum_in;

    assign a_exp    = a_i[30:23];
    assign b_exp    = b_i[30:23];
    assign a_zero   = (a_exp == 8'h00);
    assign b_zero   = (b_exp == 8'h00);
    assign a_inf    = (a_exp == 8'hFF) && (a_i[22:0] == 23'd0);
    assign b_inf    = (b_exp == 8'hFF) && (b_i[22:0] == 23'd0);
    assign a_nan    = (a_exp == 8'hFF) && (a_i[22:0] != 23'd0);
    assign b_nan    = (b_exp == 8'hFF) && (b_i[22:0] != 23'd0);
    assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
    assign special  = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    assign sign_in  = a_i[31] ^ b_i[31];
    assign accept   = in_valid_i && (state_q == ST_IDLE);
    assign rm_res   = resolve_rm(rm_i, frm_i);
    assign exp_sum_in = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'(FP32_BIAS);

    always_comb begin
        spec_res = {sign_in, 31'd0};
        if (a_nan || b_nan || inf_zero) begin
            spec_res = FP32_CANON_NAN;
        end else if (a_inf || b_inf) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                // An accept takes priority over kill_i in IDLE.
                if (in_valid_i) begin
                    state_d = special ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL: begin
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM:  state_d = kill_i ? ST_IDLE : ST_ROUND;
            ST_ROUND: state_d = kill_i ? ST_IDLE : ST_DONE;
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (kill_i || out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [47:0] acc_q, mcand_q, partial;
    logic [23:0] mplier_q;
    logic        sign_q, rm_err_q;
    logic [2:0]  rm_q;
    logic signed [9:0] exp_sum_q, norm_exp_q, norm_exp;
    logic [22:0] mant_q, norm_mant;
    logic        rnd_q, sticky_q, norm_r, norm_s;
    logic [31:0] result_q, rnd_res;

    // Partial product for the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    always_comb begin
        if (acc_q[47]) begin
            norm_exp  = exp_sum_q + 10'sd1;
            norm_mant = acc_q[46:24];
            norm_r    = acc_q[23];
            norm_s    = |acc_q[22:0];
        end else begin
            norm_exp  = exp_sum_q;
            norm_mant = acc_q[45:23];
            norm_r    = acc_q[22];
            norm_s    = |acc_q[21:0];
        end
    end

    logic        round_up, underflow, overflow, ovf_inf;
    logic [23:0] mant_inc;
    logic signed [9:0] exp_rnd;

    fpu_round_decide u_round_decide (
        .l        (mant_q[0]),
        .r        (rnd_q),
        .s        (sticky_q),
        .rm       (rm_q),
        .sign     (sign_q),
        .round_up (round_up)
    );

    // A carry out of the mantissa leaves mant_inc[22:0] at zero and bumps
    // the exponent; overflow is judged on the bumped exponent.
    always_comb begin
        mant_inc  = {1'b0, mant_q} + 24'(round_up);
        exp_rnd   = norm_exp_q + (mant_inc[23] ? 10'sd1 : 10'sd0);
        underflow = (norm_exp_q <= 10'sd0);
        overflow  = (exp_rnd >= 10'sd255);
        ovf_inf   = (rm_q == RM_RNE) || (rm_q == RM_RMM) ||
                    ((rm_q == RM_RDN) && sign_q) || ((rm_q == RM_RUP) && !sign_q);
        if (underflow) begin
            rnd_res = {sign_q, 31'd0};
        end else if (overflow) begin
            rnd_res = ovf_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, FP32_MAX_FINITE};
        end else begin
            rnd_res = {sign_q, exp_rnd[7:0], mant_inc[22:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            rm_q       <= RM_RNE;
            rm_err_q   <= 1'b0;
            exp_sum_q  <= '0;
            norm_exp_q <= '0;
            mant_q     <= '0;
            rnd_q      <= 1'b0;
            sticky_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q    <= sign_in;
                        rm_q      <= rm_is_reserved(rm_res) ? RM_RNE : rm_res;
                        rm_err_q  <= rm_is_reserved(rm_res);
                        acc_q     <= '0;
                        mcand_q   <= {24'd0, 1'b1, a_i[22:0]};
                        mplier_q  <= {1'b1, b_i[22:0]};
                        exp_sum_q <= exp_sum_in;
                        cnt_q     <= CNT_W'(MUL_CYCLES - 1);
                        if (special) begin
                            result_q <= spec_res;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_q + partial;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q - 1'b1;
                end
                ST_NORM: begin
                    norm_exp_q <= norm_exp;
                    mant_q     <= norm_mant;
                    rnd_q      <= norm_r;
                    sticky_q   <= norm_s;
                end
                ST_ROUND: begin
                    result_q <= rnd_res;
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;
    assign rm_err_o = rm_err_q;

`ifdef FPU_MUL_FLAGS_EN
    logic [4:0] flags_q, rnd_flags;
    logic       spec_nv;

    // A NaN operand masks inf*0: only a signalling NaN raises NV then.
    assign spec_nv = (a_nan || b_nan) ? ((a_nan && !a_i[22]) || (b_nan && !b_i[22])) : inf_zero;

    always_comb begin
        if (underflow) begin
            rnd_flags = 5'b00011;
        end else if (overflow) begin
            rnd_flags = 5'b00101;
        end else begin
            rnd_flags = {4'b0000, rnd_q | sticky_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            flags_q <= '0;
        end else if (accept && special) begin
            flags_q <= {spec_nv, 4'b0000};
        end else if (state_q == ST_ROUND) begin
            flags_q <= rnd_flags;
        end
    end

    assign fflags_o = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mul_sequencer
// Purpose  : Self-checking bench for fpu_mul_sequencer: directed vector table
//            plus hand-written handshake, kill and reset sequences.
// Config   : FPU_MUL_FLAGS_EN - also connects and checks fflags_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  rm = '0, frm = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        rm_err;
`ifdef FPU_MUL_FLAGS_EN
    logic [4:0]  fflags;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_mul_sequencer #(.BITS_PER_CYCLE(2)) dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .rm_i        (rm),
        .frm_i       (frm),
        .kill_i      (kill),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .rm_err_o    (rm_err)
`ifdef FPU_MUL_FLAGS_EN
        ,
        .fflags_o    (fflags)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic [31:0] res;
        logic        err;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request and return #1 after its accept edge.
    task automatic start(input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] rmv, input logic [2:0] frmv);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("start_in_ready", 32'(in_ready), 32'd1);
        a = av; b = bv; rm = rmv; frm = frmv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which out_valid is first seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic watch_no_valid(input string name);
        int seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] held;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'b000, 3'b000, 32'h40400000, 1'b0, 5'b00000, 15};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 3'b000, 3'b000, 32'h3F800002, 1'b0, 5'b00001, 15};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 3'b001, 3'b000, 32'h3F800002, 1'b0, 5'b00001, 15};
        vecs[3]  = '{32'h3F800001, 32'h3F800001, 3'b011, 3'b000, 32'h3F800003, 1'b0, 5'b00001, 15};
        vecs[4]  = '{32'h7F000000, 32'h40000000, 3'b000, 3'b000, 32'h7F800000, 1'b0, 5'b00101, 15};
        vecs[5]  = '{32'h7F000000, 32'h40000000, 3'b001, 3'b000, 32'h7F7FFFFF, 1'b0, 5'b00101, 15};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 3'b000, 3'b000, 32'h7FC00000, 1'b0, 5'b10000, 1};
        vecs[7]  = '{32'h7FA00000, 32'h3F800000, 3'b000, 3'b000, 32'h7FC00000, 1'b0, 5'b10000, 1};
        vecs[8]  = '{32'hC0000000, 32'h40400000, 3'b000, 3'b000, 32'hC0C00000, 1'b0, 5'b00000, 15};
        vecs[9]  = '{32'h3FC00000, 32'h3FC00000, 3'b000, 3'b000, 32'h40100000, 1'b0, 5'b00000, 15};
        vecs[10] = '{32'h3FC00000, 32'h3F800001, 3'b000, 3'b000, 32'h3FC00002, 1'b0, 5'b00001, 15};
        vecs[11] = '{32'h3FC00000, 32'h3F800001, 3'b001, 3'b000, 32'h3FC00001, 1'b0, 5'b00001, 15};
        vecs[12] = '{32'h3FC00000, 32'h3F800001, 3'b100, 3'b000, 32'h3FC00002, 1'b0, 5'b00001, 15};
        vecs[13] = '{32'h3FC00000, 32'h3F800001, 3'b010, 3'b000, 32'h3FC00001, 1'b0, 5'b00001, 15};
        vecs[14] = '{32'hBF800001, 32'h3FC00000, 3'b010, 3'b000, 32'hBFC00002, 1'b0, 5'b00001, 15};
        vecs[15] = '{32'hBF800001, 32'h3FC00000, 3'b011, 3'b000, 32'hBFC00001, 1'b0, 5'b00001, 15};
        vecs[16] = '{32'h3FC00000, 32'h3F800001, 3'b111, 3'b001, 32'h3FC00001, 1'b0, 5'b00001, 15};
        vecs[17] = '{32'h3FC00000, 32'h3F800001, 3'b111, 3'b101, 32'h3FC00002, 1'b1, 5'b00001, 15};
        vecs[18] = '{32'h3FC00000, 32'h3F800001, 3'b110, 3'b000, 32'h3FC00002, 1'b1, 5'b00001, 15};
        vecs[19] = '{32'hFF000000, 32'h40000000, 3'b010, 3'b000, 32'hFF800000, 1'b0, 5'b00101, 15};
        vecs[20] = '{32'hFF000000, 32'h40000000, 3'b011, 3'b000, 32'hFF7FFFFF, 1'b0, 5'b00101, 15};
        vecs[21] = '{32'h7F000000, 32'h40000000, 3'b011, 3'b000, 32'h7F800000, 1'b0, 5'b00101, 15};
        vecs[22] = '{32'h00000000, 32'hC0000000, 3'b000, 3'b000, 32'h80000000, 1'b0, 5'b00000, 1};
        vecs[23] = '{32'h00000001, 32'h3F800000, 3'b000, 3'b000, 32'h00000000, 1'b0, 5'b00000, 1};
        vecs[24] = '{32'h7F800000, 32'hC0000000, 3'b000, 3'b000, 32'hFF800000, 1'b0, 5'b00000, 1};
        vecs[25] = '{32'h7FC00001, 32'h00000000, 3'b000, 3'b000, 32'h7FC00000, 1'b0, 5'b00000, 1};
        vecs[26] = '{32'h00800000, 32'h3F000000, 3'b000, 3'b000, 32'h00000000, 1'b0, 5'b00011, 15};
        vecs[27] = '{32'h80000000, 32'h7F800000, 3'b000, 3'b000, 32'h7FC00000, 1'b0, 5'b10000, 1};
        vecs[28] = '{32'h7F800001, 32'h7F800000, 3'b000, 3'b000, 32'h7FC00000, 1'b0, 5'b10000, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rm_err", 32'(rm_err), 32'd0);
`ifdef FPU_MUL_FLAGS_EN
        check("reset fflags", 32'(fflags), 32'd0);
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].frm);
            wait_valid(n);
            check($sformatf("vec%0d latency", i), 32'(n), 32'(vecs[i].lat));
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d rm_err", i), 32'(rm_err), 32'(vecs[i].err));
`ifdef FPU_MUL_FLAGS_EN
            check($sformatf("vec%0d fflags", i), 32'(fflags), 32'(vecs[i].flags));
`endif
            @(posedge clk); #1;
        end

        // Back-pressure in DONE, then a new accept right after release
        out_ready = 1'b0;
        start(32'h3FC00000, 32'h40000000, 3'b000, 3'b000);
        wait_valid(n);
        check("hold latency", 32'(n), 32'd15);
        held = result;
        a = 32'h3FC00000; b = 32'h3FC00000; rm = 3'b000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d result", k), result, held);
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        check("hold value", held, 32'h40400000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("post-release latency", 32'(n), 32'd15);
        check("post-release result", result, 32'h40100000);
        @(posedge clk); #1;

        // kill in MUL cycle 3
        start(32'h3FC00000, 32'h40000000, 3'b000, 3'b000);
        repeat (2) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_mul in_ready", 32'(in_ready), 32'd1);
        check("kill_mul out_valid", 32'(out_valid), 32'd0);
        watch_no_valid("kill_mul no result");

        // reset low in NORM
        start(32'h3FC00000, 32'h40000000, 3'b011, 3'b000);
        repeat (12) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("reset_norm in_ready", 32'(in_ready), 32'd1);
        check("reset_norm out_valid", 32'(out_valid), 32'd0);
        check("reset_norm result", result, 32'd0);
        check("reset_norm rm_err", 32'(rm_err), 32'd0);
        watch_no_valid("reset_norm no result");

        // kill in DONE drops the held result
        out_ready = 1'b0;
        start(32'h3FC00000, 32'h3F800001, 3'b111, 3'b101);
        wait_valid(n);
        check("kill_done latency", 32'(n), 32'd15);
        check("kill_done rm_err", 32'(rm_err), 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done out_valid", 32'(out_valid), 32'd0);
        check("kill_done in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // kill together with an accept in IDLE: the accept wins
        a = 32'h3FC00000; b = 32'h40000000; rm = 3'b000; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle in_ready", 32'(in_ready), 32'd0);
        wait_valid(n);
        check("kill_idle latency", 32'(n), 32'd15);
        check("kill_idle result", result, 32'h40400000);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
